// File: rtl/reg_writeback_queue.sv
// Write-side front end for the register bank: in-order result FIFO
// with a ready/enable drain port and a newest-match forwarding lookup.
module reg_writeback_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  ALU_Valid,
    input  logic [ADDR_WIDTH-1:0] ALU_Dest,
    input  logic [DATA_WIDTH-1:0] ALU_Result,
    input  logic                  LDR_Valid,
    input  logic [ADDR_WIDTH-1:0] LDR_Dest,
    input  logic [DATA_WIDTH-1:0] LDR_Data,
    output logic                  Stall,
    output logic                  Overflow,
    output logic                  Wr_Enable,
    output logic [ADDR_WIDTH-1:0] Destination,
    output logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Reg_Ready,
    input  logic [ADDR_WIDTH-1:0] Query_Reg,
    output logic                  Query_Hit,
    output logic [DATA_WIDTH-1:0] Query_Data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] free_cnt;
    logic [1:0]    n_push;
    logic [PW-1:0] alu_slot;
    logic          push_try;
    logic          do_ldr;
    logic          do_alu;
    logic          pop;

    assign free_cnt = CW'(DEPTH) - count;
    assign Stall    = free_cnt < CW'(2);
    assign push_try = ALU_Valid | LDR_Valid;
    assign do_ldr   = LDR_Valid & ~Stall;
    assign do_alu   = ALU_Valid & ~Stall;
    assign n_push   = {1'b0, do_ldr} + {1'b0, do_alu};
    // LDR is the older instruction, so ALU lands one slot behind it
    assign alu_slot = tail + PW'(do_ldr);
    assign pop      = (count != '0) & Reg_Ready;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(n_push);
            count <= count + CW'(n_push) - CW'(pop);
            if (push_try && Stall)
                Overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset_n) begin
            if (do_ldr)
                mem[tail] <= '{dest: LDR_Dest, data: LDR_Data};
            if (do_alu)
                mem[alu_slot] <= '{dest: ALU_Dest, data: ALU_Result};
        end
    end

    always_comb begin
        Wr_Enable   = count != '0;
        Destination = '0;
        Write_Data  = '0;
        if (Wr_Enable) begin
            Destination = mem[head].dest;
            Write_Data  = mem[head].data;
        end
    end

    // Walk oldest to newest so the last match left standing is the newest
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        Query_Hit  = 1'b0;
        Query_Data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && mem[idx].dest == Query_Reg) begin
                Query_Hit  = 1'b1;
                Query_Data = mem[idx].data;
            end
        end
    end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

- Write-side front end for the register bank.
- Accepts completed results from the ALU and the load (LDR) path, buffers them in order in a small FIFO, and drives them into the bank's `Destination` and write-data inputs one per cycle under a ready/enable handshake.
- Provides a forwarding lookup so the operand-fetch side can see values not yet committed to the bank.
- Sits between the execute/load stages and the register bank.

## Interface

**Parameters**

- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 4: register index width (16 registers).
- `DEPTH`, 4: FIFO entries; must be a power of two, at least 2.

**Ports** (one clock; reset is synchronous and active-low)

- `Clock` in 1: the single clock; all state updates on its rising edge.
- `Reset_n` in 1: synchronous reset, active-low.
- `ALU_Valid` in 1: ALU result present this cycle.
- `ALU_Dest` in ADDR_WIDTH: ALU destination register.
- `ALU_Result` in DATA_WIDTH: ALU result data.
- `LDR_Valid` in 1: load result present this cycle.
- `LDR_Dest` in ADDR_WIDTH: load destination register.
- `LDR_Data` in DATA_WIDTH: load data.
- `Stall` out 1: producers must not present new results.
- `Overflow` out 1: sticky error; a push arrived while stalled.
- `Wr_Enable` out 1: head entry valid; write request to the bank.
- `Destination` out ADDR_WIDTH: head entry register index.
- `Write_Data` out DATA_WIDTH: head entry data.
- `Reg_Ready` in 1: bank accepts the write this cycle.
- `Query_Reg` in ADDR_WIDTH: register index being fetched.
- `Query_Hit` out 1: a pending entry targets `Query_Reg`.
- `Query_Data` out DATA_WIDTH: data of the newest matching pending entry.

## Operation

**Storage**
- Circular FIFO of DEPTH entries {dest, data}, with head/tail pointers and a count of width clog2(DEPTH)+1.
- Pointers wrap modulo DEPTH.

**Push**
- A push is attempted whenever `ALU_Valid` or `LDR_Valid` is high.
- Same-cycle pushes: LDR is enqueued first (older instruction), then ALU; two entries are consumed.
- Pushes are accepted only when `Stall`=0.
- A push with `Stall`=1 is dropped, and `Overflow` sets and holds until reset.

**Stall**
- `Stall` = 1 when the free-entry count is below 2; free = DEPTH − count, using the registered count.
- This guarantees a dual push always fits.

**Pop / write handshake**
- `Wr_Enable` = (count ≠ 0).
- `Destination`/`Write_Data` show the head entry, and are 0 when empty.
- The head retires on an edge where `Wr_Enable`=1 and `Reg_Ready`=1.
- The head entry holds stable while `Reg_Ready`=0.

**Simultaneous push and pop**
- Count changes by (pushes − 1).
- Pushing into the slot freed by the same-edge pop is not required, because `Stall` already reserves 2.

**Forwarding**
- Combinational search over valid entries only.
- When several entries match `Query_Reg`, the newest (closest to tail) wins.
- No match: `Query_Hit`=0, `Query_Data`=0.
- Same-cycle inputs are not searched.

**Reset**
- `Reset_n`=0 at an edge clears pointers, count and `Overflow`.
- Entry contents are don't-care but invisible.
- Any pushes or pops in that cycle are ignored, including reset mid-drain.

## Timing

- Reset values: `Stall`=0, `Overflow`=0, `Wr_Enable`=0, `Destination`=0, `Write_Data`=0, `Query_Hit`=0, `Query_Data`=0.
- Latency: push at edge N gives `Wr_Enable`=1 with that entry (if it is the head) during cycle N+1.
- Throughput: one bank write per cycle with `Reg_Ready` held high.
- Continuous single pushes with `Reg_Ready`=1 never stall.
- `Stall` updates one edge after the count changes. Producers sample it in the same cycle they present Valid.
- `Query_*` reflects state after the most recent edge; a popped entry is no longer reported after its retiring edge.

## Test plan

1. Reset, then ALU push (dest 1, 0x8) with `Reg_Ready`=1:
   - `Wr_Enable`=1, `Destination`=1, `Write_Data`=0x8 for exactly one cycle.
   - Queue then empties.
2. Same-cycle LDR (dest 2, 0x10) + ALU (dest 3, 0x20) pushes:
   - Bank sees dest 2 / 0x10, then dest 3 / 0x20 on consecutive cycles.
3. `Reg_Ready`=0, then ALU pushes of 0x1, 0x2, 0x3 to dest 5, 6, 7:
   - After the 3rd push, `Stall`=1 (free=1).
   - A further push sets `Overflow`=1 and is dropped.
   - Releasing `Reg_Ready` drains exactly 3 writes in order.
4. Pending entries dest 4=0xA then dest 4=0xB, `Query_Reg`=4:
   - `Query_Hit`=1, `Query_Data`=0xB.
   - `Query_Reg`=9 gives Hit=0, Data=0.
5. Wrap-around: push and retire 10 single results with `Reg_Ready` toggling every cycle:
   - Write order and data match push order.
   - `Stall` never asserts with at most 2 outstanding.
6. Reset asserted with 3 entries pending:
   - Next cycle `Wr_Enable`=0, `Stall`=0, `Overflow`=0.
   - No stale entries are written.
